// File: rtl/eth_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one Ethernet TX stream
// between NUM_REQ sources, with a single registered output stage.
module eth_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 256,
    parameter int ADDR_W  = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NUM_REQ-1:0]        in_valid,
    output logic [NUM_REQ-1:0]        in_ready,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    input  logic [NUM_REQ*ADDR_W-1:0] in_addr,
    input  logic [NUM_REQ-1:0]        in_sop,
    input  logic [NUM_REQ-1:0]        in_eop,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [ADDR_W-1:0]         out_addr,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic [NUM_REQ-1:0]        grant,
    output logic [31:0]               pkt_count,
    output logic [NUM_REQ-1:0]        sop_err
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state, state_nxt;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [IDX_W-1:0]   last, last_nxt;
    logic [IDX_W-1:0]   owner, pick;
    logic               found;
    logic [NUM_REQ-1:0] eligible;
    logic               accept;
    logic               sel_eop;

    assign eligible = in_valid & in_sop;

    always_comb begin
        owner = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) owner = IDX_W'(i);
        end
    end

    // Search upward from the previous owner so every source gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!found && eligible[(int'(last) + k) % NUM_REQ]) begin
                found = 1'b1;
                pick  = IDX_W'((int'(last) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (resetn && state == GRANT && (!out_valid || out_ready)) begin
            in_ready = grant;
        end
    end

    assign accept  = |(in_valid & in_ready);
    assign sel_eop = in_eop[owner];

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        last_nxt  = last;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_nxt = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (accept && sel_eop) begin
                    grant_nxt = '0;
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            grant     <= '0;
            last      <= IDX_W'(NUM_REQ - 1);
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            pkt_count <= '0;
            sop_err   <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            last  <= last_nxt;
            if (accept) begin
                out_valid <= 1'b1;
                out_data  <= in_data[int'(owner)*DATA_W +: DATA_W];
                out_addr  <= in_addr[int'(owner)*ADDR_W +: ADDR_W];
                out_sop   <= in_sop[owner];
                out_eop   <= sel_eop;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (accept && sel_eop) pkt_count <= pkt_count + 32'd1;
            sop_err <= sop_err | (in_valid & ~in_sop & ~grant);
        end
    end
endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Bench for eth_tx_arbiter: per-source packet queues as the reference,
// checked beat by beat at the output plus directed arbitration cases.
module tb_eth_tx_arbiter;
    localparam int NR = 4;
    localparam int DW = 256;
    localparam int AW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [AW-1:0] addr;
        logic          sop;
        logic          eop;
    } beat_t;

    logic             clk = 1'b0;
    logic             resetn;
    logic [NR-1:0]    in_valid, in_ready, in_sop, in_eop;
    logic [NR*DW-1:0] in_data;
    logic [NR*AW-1:0] in_addr;
    logic             out_valid, out_ready, out_sop, out_eop;
    logic [DW-1:0]    out_data;
    logic [AW-1:0]    out_addr;
    logic [NR-1:0]    grant, sop_err;
    logic [31:0]      pkt_count;

    always #5 clk = ~clk;

    eth_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_addr(in_addr),
        .in_sop(in_sop), .in_eop(in_eop),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr),
        .out_sop(out_sop), .out_eop(out_eop),
        .grant(grant), .pkt_count(pkt_count), .sop_err(sop_err)
    );

    beat_t       src_q[NR][$];
    beat_t       exp_q[NR][$];
    int          sop_order[$];
    int          sop_cyc[$];
    int          gcnt[NR];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] pkt_exp = '0;
    bit          vld_rand = 0, bad2 = 0, rdy_force = 1;
    int          rdy_mode = 0;
    bit          in_pkt = 0, acc_prev = 0, pv = 0, pr = 0;
    int          cur_src = 0;
    beat_t       acc_beat, pbeat;

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(int s, int len, bit plain = 0);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            for (int w = 0; w < DW/32; w++) b.data[w*32 +: 32] = $urandom;
            b.data[DW-1 -: 8] = 8'(s);
            if (plain) b.data = DW'(k);
            b.addr = AW'($urandom);
            b.sop  = (k == 0);
            b.eop  = (k == len - 1);
            src_q[s].push_back(b);
            exp_q[s].push_back(b);
        end
        pkt_exp++;
    endtask

    function automatic bit pending();
        bit p = 0;
        for (int i = 0; i < NR; i++)
            if (src_q[i].size() > 0 || exp_q[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic drive();
        in_valid = '0; in_sop = '0; in_eop = '0;
        in_data  = '0; in_addr = '0;
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0 && (!vld_rand || $urandom_range(3) != 0)) begin
                in_valid[i]           = 1'b1;
                in_sop[i]             = src_q[i][0].sop;
                in_eop[i]             = src_q[i][0].eop;
                in_data[i*DW +: DW]   = src_q[i][0].data;
                in_addr[i*AW +: AW]   = src_q[i][0].addr;
            end
        end
        if (bad2) begin
            in_valid[2]         = 1'b1;
            in_sop[2]           = 1'b0;
            in_data[2*DW +: DW] = '1;
        end
        if (rdy_mode == 0) out_ready = 1'b1;
        else if (rdy_mode == 1) out_ready = ($urandom_range(2) != 0);
        else out_ready = rdy_force;
    endtask

    task automatic cycle();
        drive();
        #1;
        if (pv && !pr) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_data", out_data, pbeat.data);
            chk("hold_ctl", {out_addr, out_sop, out_eop}, {pbeat.addr, pbeat.sop, pbeat.eop});
        end
        if (acc_prev) begin
            chk("lat_valid", out_valid, 1);
            chk("lat_data", out_data, acc_beat.data);
            chk("lat_ctl", {out_addr, out_sop, out_eop}, {acc_beat.addr, acc_beat.sop, acc_beat.eop});
        end
        chk("grant_onehot0", $onehot0(grant), 1);
        chk("in_ready", in_ready, (grant != 0 && (!out_valid || out_ready)) ? grant : '0);
        if (bad2) chk("bad_ready", in_ready[2], 0);
        if (out_valid && out_ready) begin
            int s;
            s = int'(out_data[DW-1 -: 8]);
            chk("src_range", s < NR, 1);
            if (s < NR) begin
                chk("exp_avail", exp_q[s].size() > 0, 1);
                if (exp_q[s].size() > 0) begin
                    chk("out_beat", {out_data, out_addr, out_sop, out_eop}, exp_q[s][0]);
                    void'(exp_q[s].pop_front());
                end
            end
            if (out_sop) begin
                chk("atomic_sop", in_pkt, 0);
                in_pkt  = 1;
                cur_src = s;
                sop_order.push_back(s);
                sop_cyc.push_back(cyc);
            end else begin
                chk("atomic_src", in_pkt && s == cur_src, 1);
            end
            if (out_eop) in_pkt = 0;
        end
        acc_prev = 0;
        for (int i = 0; i < NR; i++) begin
            if (in_valid[i] && in_ready[i] && !(bad2 && i == 2) && src_q[i].size() > 0) begin
                acc_beat = src_q[i].pop_front();
                acc_prev = 1;
            end
            if (grant[i] && $onehot(grant)) gcnt[i]++;
        end
        pv    = out_valid;
        pr    = out_ready;
        pbeat = {out_data, out_addr, out_sop, out_eop};
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        int n = 0;
        while ((pending() || out_valid) && n < 3000) begin
            cycle();
            n++;
        end
        chk("drain_timeout", n < 3000, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn = 1'b0; out_ready = 1'b0;
        in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_addr = '0;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_count", pkt_count, 0);
        chk("rst_err", sop_err, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_data", {out_data, out_addr, out_sop, out_eop}, 0);

        // All sources request continuously from reset
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NR; s++) add_pkt(s, 2);
        resetn = 1'b1;
        drain();
        chk("fair_n", sop_order.size(), 8);
        for (int k = 0; k < 8 && k < sop_order.size(); k++)
            chk($sformatf("fair_order%0d", k), sop_order[k], k % NR);
        for (int k = 1; k < 8 && k < sop_cyc.size(); k++)
            chk($sformatf("fair_gap%0d", k), sop_cyc[k] - sop_cyc[k-1], 3);
        chk("fair_count", pkt_count, pkt_exp);

        // Single source, data 0,1,2
        for (int i = 0; i < NR; i++) gcnt[i] = 0;
        add_pkt(0, 3, 1);
        drain();
        chk("single_grant0", gcnt[0], 3);
        chk("single_grant_other", gcnt[1] + gcnt[2] + gcnt[3], 0);
        chk("single_count", pkt_count, pkt_exp);

        // Random traffic with random gaps and backpressure
        repeat (40) add_pkt($urandom_range(NR-1), $urandom_range(1, 4));
        vld_rand = 1; rdy_mode = 1;
        drain();
        vld_rand = 0; rdy_mode = 0;
        chk("rand_count", pkt_count, pkt_exp);
        chk("rand_err", sop_err, 0);

        // Five stalled cycles mid-packet
        add_pkt(3, 6);
        rdy_mode = 2; rdy_force = 1;
        repeat (3) cycle();
        rdy_force = 0;
        repeat (5) cycle();
        chk("bp_valid", out_valid, 1);
        chk("bp_ready", in_ready, 0);
        rdy_mode = 0;
        drain();
        chk("bp_count", pkt_count, pkt_exp);

        // req2 valid without sop while req1 owns the stream
        add_pkt(1, 4);
        n = 0;
        while (grant != 4'b0010 && n < 20) begin cycle(); n++; end
        chk("proto_grant_wait", n < 20, 1);
        bad2 = 1;
        drain();
        bad2 = 0;
        chk("proto_err", sop_err, 4'b0100);
        chk("proto_count", pkt_count, pkt_exp);

        // Reset on beat 2 of a 4-beat packet
        add_pkt(0, 4);
        n = 0;
        while (src_q[0].size() > 2 && n < 20) begin cycle(); n++; end
        chk("rstmid_wait", n < 20, 1);
        resetn = 1'b0;
        drive();
        #1;
        chk("rstmid_ready", in_ready, 0);
        @(posedge clk);
        @(negedge clk);
        chk("rstmid_valid", out_valid, 0);
        chk("rstmid_grant", grant, 0);
        chk("rstmid_count", pkt_count, 0);
        chk("rstmid_err", sop_err, 0);
        for (int i = 0; i < NR; i++) begin src_q[i].delete(); exp_q[i].delete(); end
        in_pkt = 0; acc_prev = 0; pv = 0; pr = 0;
        pkt_exp = '0;
        sop_order.delete();
        resetn = 1'b1;
        add_pkt(1, 2);
        add_pkt(2, 2);
        drain();
        chk("rstmid_n", sop_order.size(), 2);
        if (sop_order.size() == 2) begin
            chk("rstmid_first", sop_order[0], 1);
            chk("rstmid_second", sop_order[1], 2);
        end
        chk("rstmid_count2", pkt_count, pkt_exp);

        // Counter wrap
        force dut.pkt_count = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.pkt_count;
        chk("wrap_pre", pkt_count, 32'hFFFF_FFFF);
        pkt_exp = 32'hFFFF_FFFF;
        add_pkt(0, 2);
        drain();
        chk("wrap_count", pkt_count, pkt_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Shares one Ethernet transmit stream toward the NAP between NUM_REQ packet sources, such as traffic generators and a loopback return path.
- Arbitration is round-robin and packet-atomic: once a source is granted, it keeps the stream from its sop beat through its eop beat.
- Output is a single registered stage, placed between the requesters and the NAP ETH stream port.
- Provides a packet counter and per-source sticky protocol-error flags for status/LED logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 256, beat width in bits.
- ADDR_W, 4, stream address width in bits.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- in_valid  in  NUM_REQ  per-requester beat valid.
- in_ready  out  NUM_REQ  per-requester beat accepted.
- in_data  in  NUM_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W].
- in_addr  in  NUM_REQ*ADDR_W  requester i address in bits [i*ADDR_W +: ADDR_W].
- in_sop  in  NUM_REQ  start-of-packet.
- in_eop  in  NUM_REQ  end-of-packet.
- out_valid  out  1  output beat valid.
- out_ready  in  1  NAP ready.
- out_data  out  DATA_W  output data.
- out_addr  out  ADDR_W  output address.
- out_sop  out  1  output start-of-packet.
- out_eop  out  1  output end-of-packet.
- grant  out  NUM_REQ  one-hot current owner; 0 when IDLE.
- pkt_count  out  32  packets forwarded.
- sop_err  out  NUM_REQ  sticky error: valid without sop while not granted.

Behaviour:
- Reset:
  - resetn is synchronous, active-low; clock is clk.
  - While resetn=0: state=IDLE, grant=0, last=NUM_REQ-1, out_valid=0, out_data=0, out_addr=0, out_sop=0, out_eop=0, pkt_count=0, sop_err=0, in_ready=0.
  - Reset mid-packet truncates the packet; no eop is emitted.
- Transfer rule: a beat transfers on any cycle where valid and ready are both 1, on either side.
- Eligibility: requester i is eligible when in_valid[i]=1 and in_sop[i]=1.
- State IDLE:
  - in_ready=0 for all requesters.
  - If any requester is eligible, pick the first eligible index searching upward from last+1, with modulo wrap.
  - Register the pick into grant and move to GRANT. This costs one arbitration cycle.
- State GRANT, with owner g:
  - in_ready[g] = !out_valid || out_ready; this is combinational from out_ready.
  - in_ready of every other requester is 0.
  - On accept (in_valid[g] && in_ready[g]): load out_data/out_addr/out_sop/out_eop from requester g and set out_valid=1 on the next cycle.
  - Accept of an eop beat: next state IDLE, last=g, grant=0, pkt_count += 1 (wraps at 2^32).
- Output register:
  - If out_ready=1 and there is no accept, out_valid clears.
  - Payload holds while out_valid=1 and out_ready=0.
- Latency and throughput:
  - Accept-to-out_valid latency is 1 cycle.
  - Back-to-back beats inside a packet run at full rate.
  - Exactly one bubble cycle occurs between packets: the IDLE arbitration cycle.
- Single-beat packet (sop=eop=1): valid; grant is held for one accepted beat.
- Mid-packet gaps: if the owner deasserts in_valid mid-packet, grant is held indefinitely. There is no timeout.
- A sop seen from the owner after its first beat is forwarded unchanged; it is not checked.
- sop_err[i] sets on any cycle where in_valid[i]=1, in_sop[i]=0 and grant[i]=0. It clears only on reset. The offending beat is never accepted.
- Simultaneous requests: round-robin guarantees each eligible requester is granted within NUM_REQ packets.

Test Plan:
- Single source: req0 sends 3 beats (data 0,1,2; sop on beat 0, eop on beat 2) with out_ready=1 → out beats 0,1,2 one cycle after each accept; grant=0001 for 3 cycles; pkt_count=1.
- Fairness: all 4 requesters hold eligible 2-beat packets continuously from reset → grant order 0,1,2,3,0,…; one bubble cycle between packets; pkt_count=8 after 8 packets.
- Backpressure: out_ready held 0 for 5 cycles mid-packet → out_data stable, in_ready[g]=0 after the stage fills, no beat lost or duplicated; order preserved on release.
- Protocol error: req2 presents valid with sop=0 while req1 is granted → sop_err=0100, req2 never receives ready, req1 stream is unaffected.
- Reset mid-packet: resetn=0 on beat 2 of a 4-beat packet → next cycle out_valid=0, grant=0, pkt_count=0; the following packet from req1 is granted first (last=3 wraps to 0, so req0 is searched first if eligible, else req1).
- Wrap: preload pkt_count to 0xFFFFFFFF via forced stimulus, send one packet → pkt_count=0.
